// File: rtl/axil_led_regs.sv
// rtl/axil_led_regs.sv - AXI4-lite register bank with ID, scratch, LED, LED toggle and cycle counter
module axil_led_regs #(
    parameter int unsigned              DATA_WIDTH = 32,
    parameter int unsigned              ADDR_WIDTH = 16,
    parameter int unsigned              STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned              LED_WIDTH  = 8,
    parameter logic [31:0]              ID_VALUE   = 32'h1CA9_0001,
    parameter logic [LED_WIDTH-1:0]     LED_RESET  = '0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,

    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,

    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,

    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,

    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,

    output logic [LED_WIDTH-1:0]    led
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] IDX_ID      = 6'd0;
    localparam logic [5:0] IDX_SCRATCH = 6'd1;
    localparam logic [5:0] IDX_LED     = 6'd2;
    localparam logic [5:0] IDX_TOGGLE  = 6'd3;
    localparam logic [5:0] IDX_CYCLE   = 6'd4;

    // Write-side holding state: a beat that arrives before its partner waits here
    logic                   aw_held_q, aw_held_d;
    logic [5:0]             aw_idx_q, aw_idx_d;
    logic                   w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;

    logic                   bvalid_q, bvalid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic [LED_WIDTH-1:0]   led_q, led_d;
    logic [DATA_WIDTH-1:0]  scratch_q, scratch_d;
    logic [31:0]            cycle_q, cycle_d;

    logic                   aw_fire, w_fire, ar_fire, commit;
    logic [5:0]             wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]  wr_data, wr_mask, led_ext, rd_val;
    logic [STRB_WIDTH-1:0]  wr_strb;
    logic [1:0]             rd_resp;

    // prot and the ignored address bits are intentionally unused
    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    // Readies are gated by rst so they read low while reset is held
    assign s_axil_awready = !rst && !aw_held_q && !bvalid_q;
    assign s_axil_wready  = !rst && !w_held_q && !bvalid_q;
    assign s_axil_arready = !rst && !rvalid_q;

    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid && s_axil_wready;
    assign ar_fire = s_axil_arvalid && s_axil_arready;

    // Commit once both beats are available, whether held or arriving now
    assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);
    assign wr_idx  = aw_held_q ? aw_idx_q : s_axil_awaddr[7:2];
    assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;
    assign rd_idx  = s_axil_araddr[7:2];

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;
    assign led           = led_q;

    // Expand byte strobes to a bit mask and zero-extend the LED register for reads
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            wr_mask[8*i +: 8] = {8{wr_strb[i]}};
        end
        led_ext = '0;
        led_ext[LED_WIDTH-1:0] = led_q;
    end

    // Read decode; values are taken before any same-edge write commit lands
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            IDX_ID:      rd_val = ID_VALUE;
            IDX_SCRATCH: rd_val = scratch_q;
            IDX_LED:     rd_val = led_ext;
            IDX_TOGGLE:  rd_val = '0;
            IDX_CYCLE:   rd_val = cycle_q;
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    // Next-state: write holds, commit, responses and register updates
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        led_d     = led_q;
        scratch_d = scratch_q;
        cycle_d   = cycle_q + 32'd1;

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_OKAY;
            case (wr_idx)
                IDX_ID:      ;
                IDX_SCRATCH: scratch_d = (scratch_q & ~wr_mask) | (wr_data & wr_mask);
                IDX_LED:     led_d = (led_q & ~wr_mask[LED_WIDTH-1:0])
                                   | (wr_data[LED_WIDTH-1:0] & wr_mask[LED_WIDTH-1:0]);
                IDX_TOGGLE:  led_d = led_q ^ (wr_data[LED_WIDTH-1:0] & wr_mask[LED_WIDTH-1:0]);
                IDX_CYCLE:   cycle_d = '0;
                default:     bresp_d = RESP_SLVERR;
            endcase
        end else begin
            if (aw_fire) begin
                aw_held_d = 1'b1;
                aw_idx_d  = s_axil_awaddr[7:2];
            end
            if (w_fire) begin
                w_held_d = 1'b1;
                wdata_d  = s_axil_wdata;
                wstrb_d  = s_axil_wstrb;
            end
        end

        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = rd_resp;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            led_q     <= LED_RESET;
            scratch_q <= '0;
            cycle_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            cycle_q   <= cycle_d;
        end
    end

endmodule

// File: tb/tb_axil_led_regs.sv
// tb/tb_axil_led_regs.sv - directed self-checking bench for axil_led_regs
module tb_axil_led_regs;

    logic        clk;
    logic        rst;
    logic [15:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [15:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [7:0]  led;

    int n_checks;
    int n_fail;

    axil_led_regs dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .led            (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the B handshake
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int bwait);
        bit aw_done;
        bit w_done;
        int n;
        aw_done = 0;
        w_done  = 0;
        n       = 0;
        s_axil_awaddr  = addr;
        s_axil_wdata   = data;
        s_axil_wstrb   = strb;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            if (s_axil_awvalid && s_axil_awready) aw_done = 1;
            if (s_axil_wvalid && s_axil_wready) w_done = 1;
            @(negedge clk);
            if (aw_done) s_axil_awvalid = 1'b0;
            if (w_done) s_axil_wvalid = 1'b0;
            n++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("wr_handshake_timeout", 32'(n < 50), 32'd1);
        bwait = 0;
        while (!s_axil_bvalid && bwait < 50) begin
            @(negedge clk);
            bwait++;
        end
        check("wr_bvalid_timeout", 32'(bwait < 50), 32'd1);
        resp = s_axil_bresp;
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
    endtask

    // Called at a negedge; returns at a negedge after the R handshake
    task automatic axi_read(input logic [15:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int rwait);
        int n;
        n = 0;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rd_arready_timeout", 32'(n < 50), 32'd1);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        rwait = 0;
        while (!s_axil_rvalid && rwait < 50) begin
            @(negedge clk);
            rwait++;
        end
        check("rd_rvalid_timeout", 32'(rwait < 50), 32'd1);
        data = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [1:0]  resp;
        int          lat;

        n_checks = 0;
        n_fail   = 0;
        rst            = 1'b1;
        s_axil_awaddr  = '0;
        s_axil_awprot  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axil_awready), 32'd0);
        check("rst_wready", 32'(s_axil_wready), 32'd0);
        check("rst_arready", 32'(s_axil_arready), 32'd0);
        check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("rst_rdata", s_axil_rdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_arready", 32'(s_axil_arready), 32'd1);
        check("rel_awready", 32'(s_axil_awready), 32'd1);
        check("rel_wready", 32'(s_axil_wready), 32'd1);

        // ID and LED reset reads
        axi_read(16'h0000, rd, resp, lat);
        check("id_rdata", rd, 32'h1CA9_0001);
        check("id_rresp", 32'(resp), 32'd0);
        check("id_rlatency", 32'(lat), 32'd0);
        axi_read(16'h0008, rd, resp, lat);
        check("led_reset_rdata", rd, 32'd0);

        // LED byte write, toggle, toggle read-back
        axi_write(16'h0008, 32'h0000_00A5, 4'b0001, resp, lat);
        check("led_wr_blatency", 32'(lat), 32'd0);
        check("led_wr_bresp", 32'(resp), 32'd0);
        check("led_wr_led", 32'(led), 32'hA5);
        axi_write(16'h000C, 32'h0000_000F, 4'b1111, resp, lat);
        check("toggle_bresp", 32'(resp), 32'd0);
        check("toggle_led", 32'(led), 32'hAA);
        axi_read(16'h000C, rd, resp, lat);
        check("toggle_rdata", rd, 32'd0);
        check("toggle_rresp", 32'(resp), 32'd0);

        // W three cycles ahead of AW, then a four-cycle B stall
        s_axil_awaddr = 16'h0008;
        s_axil_wdata  = 32'hFFFF_FF3C;
        s_axil_wstrb  = 4'b1111;
        s_axil_wvalid = 1'b1;
        check("stall_wready0", 32'(s_axil_wready), 32'd1);
        @(negedge clk);
        s_axil_wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stall_wready_held", 32'(s_axil_wready), 32'd0);
            check("stall_awready_open", 32'(s_axil_awready), 32'd1);
            check("stall_no_bvalid", 32'(s_axil_bvalid), 32'd0);
            check("stall_led_pre", 32'(led), 32'hAA);
            @(negedge clk);
        end
        s_axil_awvalid = 1'b1;
        check("stall_led_before_aw", 32'(led), 32'hAA);
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_bvalid_held", 32'(s_axil_bvalid), 32'd1);
            check("stall_bresp_held", 32'(s_axil_bresp), 32'd0);
            check("stall_awready_blocked", 32'(s_axil_awready), 32'd0);
            check("stall_wready_blocked", 32'(s_axil_wready), 32'd0);
            check("stall_led_post", 32'(led), 32'h3C);
            @(negedge clk);
        end
        s_axil_bready = 1'b1;
        @(negedge clk);
        s_axil_bready = 1'b0;
        check("stall_bvalid_done", 32'(s_axil_bvalid), 32'd0);
        check("stall_awready_back", 32'(s_axil_awready), 32'd1);
        axi_read(16'h0008, rd, resp, lat);
        check("led_upper_bits_zero", rd, 32'h0000_003C);

        // Scratch byte strobes
        axi_write(16'h0004, 32'h1122_3344, 4'b1111, resp, lat);
        axi_write(16'h0004, 32'hDEAD_BEEF, 4'b0110, resp, lat);
        axi_read(16'h0004, rd, resp, lat);
        check("scratch_strb", rd, 32'h11AD_BE44);

        // Counter clear and read six edges after the clearing commit
        axi_write(16'h0010, 32'h0000_FFFF, 4'b0000, resp, lat);
        check("cycle_wr_bresp", 32'(resp), 32'd0);
        repeat (4) @(negedge clk);
        axi_read(16'h0010, rd, resp, lat);
        check("cycle_after_clear", rd, 32'd5);
        axi_read(16'h0010, rd2, resp, lat);
        check("cycle_back_to_back", rd2 - rd, 32'd2);

        // Undecoded addresses, ID write, aliasing
        axi_read(16'h0040, rd, resp, lat);
        check("slverr_rd40_resp", 32'(resp), 32'd2);
        check("slverr_rd40_data", rd, 32'd0);
        axi_write(16'h003C, 32'hFFFF_FFFF, 4'b1111, resp, lat);
        check("slverr_wr3c_resp", 32'(resp), 32'd2);
        check("slverr_wr3c_led", 32'(led), 32'h3C);
        axi_read(16'h0014, rd, resp, lat);
        check("slverr_rd14_resp", 32'(resp), 32'd2);
        check("slverr_rd14_data", rd, 32'd0);
        axi_write(16'h0000, 32'h0000_0000, 4'b1111, resp, lat);
        check("id_wr_bresp", 32'(resp), 32'd0);
        axi_read(16'h0000, rd, resp, lat);
        check("id_after_wr", rd, 32'h1CA9_0001);
        axi_read(16'h0104, rd, resp, lat);
        check("alias_scratch", rd, 32'h11AD_BE44);

        // Reset asserted during a B stall
        s_axil_awaddr  = 16'h0008;
        s_axil_wdata   = 32'h0000_0077;
        s_axil_wstrb   = 4'b0001;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("midrst_bvalid_pre", 32'(s_axil_bvalid), 32'd1);
        check("midrst_led_pre", 32'(led), 32'h77);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("midrst_led", 32'(led), 32'd0);
        check("midrst_awready", 32'(s_axil_awready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("postrst_awready", 32'(s_axil_awready), 32'd1);
        axi_read(16'h0004, rd, resp, lat);
        check("postrst_scratch", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
